// File: rtl/paddle_video_out.sv
// XGA raster generator that paints a paddle box over a background colour.
// Stage 0 holds the free-running h/v counters and the per-frame shadow box;
// stage 1 registers every output from stage-0 values, so nothing is combinational
// from inputs to outputs.
module paddle_video_out #(
    parameter int unsigned H_VISIBLE  = 1024,
    parameter int unsigned H_FP       = 24,
    parameter int unsigned H_SYNC     = 136,
    parameter int unsigned H_BP       = 160,
    parameter int unsigned V_VISIBLE  = 768,
    parameter int unsigned V_FP       = 3,
    parameter int unsigned V_SYNC     = 6,
    parameter int unsigned V_BP       = 29,
    parameter logic [11:0] PADDLE_RGB = 12'hFFF,
    parameter logic [11:0] BG_RGB     = 12'h000
) (
    input  logic        vclock,
    input  logic        reset,
    input  logic [10:0] minX,
    input  logic [10:0] maxX,
    input  logic [9:0]  minY,
    input  logic [9:0]  maxY,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] rgb,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS        = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0]  V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [10:0] h;
    logic [9:0]  v;
    logic [10:0] sMinX;
    logic [10:0] sMaxX;
    logic [9:0]  sMinY;
    logic [9:0]  sMaxY;

    logic        lastPixel;
    logic        deC;
    logic        insideC;
    logic        hsyncC;
    logic        vsyncC;
    logic [11:0] rgbC;

    assign lastPixel = (h == H_LAST) && (v == V_LAST);

    // Stage 0: pixel and line counters
    always_ff @(posedge vclock) begin
        if (reset) begin
            h <= 11'd0;
            v <= 10'd0;
        end else if (h == H_LAST) begin
            h <= 11'd0;
            v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
            h <= h + 11'd1;
        end
    end

    // Shadow box: sampled only on the last pixel of a frame so geometry never tears
    always_ff @(posedge vclock) begin
        if (reset) begin
            sMinX <= 11'd1;
            sMaxX <= 11'd0;
            sMinY <= 10'd1;
            sMaxY <= 10'd0;
        end else if (lastPixel) begin
            sMinX <= minX;
            sMaxX <= maxX;
            sMinY <= minY;
            sMaxY <= maxY;
        end
    end

    // Decode of the current counter position into next output values
    always_comb begin
        deC     = 1'b0;
        insideC = 1'b0;
        hsyncC  = 1'b1;
        vsyncC  = 1'b1;
        rgbC    = 12'h000;
        deC     = (h < H_VIS) && (v < V_VIS);
        insideC = (h >= sMinX) && (h <= sMaxX) && (v >= sMinY) && (v <= sMaxY);
        if ((h >= H_SYNC_START) && (h < H_SYNC_END)) begin
            hsyncC = 1'b0;
        end
        if ((v >= V_SYNC_START) && (v < V_SYNC_END)) begin
            vsyncC = 1'b0;
        end
        if (deC) begin
            rgbC = insideC ? PADDLE_RGB : BG_RGB;
        end
    end

    // Stage 1: registered outputs, one clock behind the counters
    always_ff @(posedge vclock) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            rgb         <= 12'h000;
            hcount      <= 11'd0;
            vcount      <= 10'd0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hsyncC;
            vsync       <= vsyncC;
            de          <= deC;
            rgb         <= rgbC;
            hcount      <= h;
            vcount      <= v;
            frame_start <= (h == 11'd0) && (v == 10'd0);
        end
    end

endmodule

// File: tb/tb_paddle_video_out.sv
// Scoreboard bench for paddle_video_out on a reduced raster so many frames fit
// in a short run. The reference model tracks the pixel stream as a linear index
// since reset and derives position, sync and colour with plain arithmetic.
module tb_paddle_video_out;

    localparam int HV  = 40;
    localparam int HFP = 4;
    localparam int HS  = 6;
    localparam int HBP = 6;
    localparam int VV  = 30;
    localparam int VFP = 2;
    localparam int VS  = 3;
    localparam int VBP = 3;
    localparam int HT  = HV + HFP + HS + HBP;
    localparam int VT  = VV + VFP + VS + VBP;
    localparam int FT  = HT * VT;
    localparam int MAX_FAILS = 40;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
        logic [10:0] hc;
        logic [9:0]  vc;
        logic        fs;
    } outv_t;

    logic        vclock;
    logic        reset;
    logic [10:0] minX;
    logic [10:0] maxX;
    logic [9:0]  minY;
    logic [9:0]  maxY;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] rgb;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        frame_start;

    int tests = 0;
    int fails = 0;

    outv_t expQ[$];

    paddle_video_out #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .PADDLE_RGB(12'hFFF), .BG_RGB(12'h000)
    ) dut (
        .vclock(vclock), .reset(reset),
        .minX(minX), .maxX(maxX), .minY(minY), .maxY(maxY),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
        .hcount(hcount), .vcount(vcount), .frame_start(frame_start)
    );

    initial vclock = 1'b0;
    always #5 vclock = ~vclock;

    task automatic finishRun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Reference model: pixel k after reset sits at (k mod HT, (k div HT) mod VT)
    int  k = 0;
    bit  started = 0;
    int  bMinX = 1, bMaxX = 0, bMinY = 1, bMaxY = 0;

    function automatic outv_t expectPix(int x, int y);
        outv_t e;
        bit inBox;
        e.hc  = 11'(x);
        e.vc  = 10'(y);
        e.de  = (x < HV) && (y < VV);
        e.hs  = !((x >= HV + HFP) && (x < HV + HFP + HS));
        e.vs  = !((y >= VV + VFP) && (y < VV + VFP + VS));
        e.fs  = (x == 0) && (y == 0);
        inBox = (x >= bMinX) && (x <= bMaxX) && (y >= bMinY) && (y <= bMaxY);
        e.rgb = !e.de ? 12'h000 : (inBox ? 12'hFFF : 12'h000);
        return e;
    endfunction

    // Predict the output that each clock edge will present
    always @(posedge vclock) begin
        outv_t e;
        if (reset) begin
            e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 12'h000, hc: 11'd0, vc: 10'd0, fs: 1'b0};
            k = 0;
            bMinX = 1; bMaxX = 0; bMinY = 1; bMaxY = 0;
            started = 1;
            expQ.push_back(e);
        end else if (started) begin
            e = expectPix(k % HT, (k / HT) % VT);
            if (k % FT == FT - 1) begin
                bMinX = int'(minX); bMaxX = int'(maxX);
                bMinY = int'(minY); bMaxY = int'(maxY);
            end
            k++;
            expQ.push_back(e);
        end
    end

    // Timing-property trackers (cycle-domain view of the sync waveforms)
    int cyc = 0;
    int deRun = 0, hsRun = 0, vsRun = 0;
    int lastDeRise = -1, lastVsFall = -1;
    logic prevDe = 1'b0, prevHs = 1'b1, prevVs = 1'b1;

    task automatic checkInt(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop and compare every presented pixel, then check run lengths
    always @(posedge vclock) begin
        outv_t e;
        outv_t a;
        #1;
        cyc++;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            a = '{hs: hsync, vs: vsync, de: de, rgb: rgb, hc: hcount, vc: vcount, fs: frame_start};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL pixel(cycle %0d): got hs=%b vs=%b de=%b rgb=%h h=%0d v=%0d fs=%b, expected hs=%b vs=%b de=%b rgb=%h h=%0d v=%0d fs=%b",
                         cyc, a.hs, a.vs, a.de, a.rgb, a.hc, a.vc, a.fs,
                         e.hs, e.vs, e.de, e.rgb, e.hc, e.vc, e.fs);
            end
        end else if (started) begin
            checkInt("scoreboard_empty", 0, 1);
        end

        if (reset) begin
            deRun = 0; hsRun = 0; vsRun = 0;
            lastDeRise = -1; lastVsFall = -1;
        end else if (started) begin
            if (de && !prevDe) lastDeRise = cyc;
            if (de) deRun++;
            else if (deRun > 0) begin
                checkInt("de_run", deRun, HV);
                deRun = 0;
            end
            if (!hsync && prevHs && lastDeRise >= 0 && (cyc - lastDeRise) < HT)
                checkInt("de_to_hsync", cyc - lastDeRise, HV + HFP);
            if (!hsync) hsRun++;
            else if (hsRun > 0) begin
                checkInt("hsync_low", hsRun, HS);
                hsRun = 0;
            end
            if (!vsync && prevVs) begin
                if (lastVsFall >= 0) checkInt("vsync_period", cyc - lastVsFall, FT);
                lastVsFall = cyc;
            end
            if (!vsync) vsRun++;
            else if (vsRun > 0) begin
                checkInt("vsync_low", vsRun, VS * HT);
                vsRun = 0;
            end
        end
        prevDe = de; prevHs = hsync; prevVs = vsync;
        if (fails >= MAX_FAILS) finishRun();
    end

    // Wait (bounded) until the DUT presents pixel (x,y); leaves time at edge+3
    task automatic waitPix(int x, int y);
        bit hit = 0;
        for (int i = 0; i < FT + 8 && !hit; i++) begin
            @(posedge vclock);
            #1;
            if (int'(hcount) == x && int'(vcount) == y) hit = 1;
        end
        #2;
        if (!hit) checkInt("wait_timeout", 0, 1);
    endtask

    task automatic setBox(int x0, int x1, int y0, int y1);
        minX = 11'(x0); maxX = 11'(x1); minY = 10'(y0); maxY = 10'(y1);
    endtask

    initial begin
        reset = 1'b1;
        setBox(10, 20, 10, 20);
        repeat (3) @(posedge vclock);
        #3 reset = 1'b0;

        // Frame 0 empty, frame 1 shows 10..20 box; move minX mid-frame 1
        waitPix(0, 0);
        waitPix(0, 0);
        waitPix(0, 12);
        setBox(14, 20, 10, 20);

        // Degenerate horizontal box for frame 3
        waitPix(0, 0);
        waitPix(5, 5);
        setBox(25, 24, 10, 20);

        // Box extending past the visible area for frame 4
        waitPix(0, 0);
        waitPix(3, 3);
        setBox(35, 60, 0, 1000);

        // Mid-frame reset pulse; raster restarts with an empty box
        waitPix(0, 0);
        waitPix(24, 20);
        reset = 1'b1;
        @(posedge vclock);
        #3 reset = 1'b0;

        // Randomised box updates at random instants, including degenerate boxes
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(50, FT)) @(posedge vclock);
            #3;
            setBox($urandom_range(0, 50), $urandom_range(0, 50),
                   $urandom_range(0, 36), $urandom_range(0, 36));
        end

        repeat (2 * FT) @(posedge vclock);
        #3;
        finishRun();
    end

endmodule

// File: doc/paddle_video_out.md
Name: paddle_video_out

Overview:
- Video-side consumer of the paddle bounding box (minX/maxX/minY/maxY) and the source of the vsync that the paddle controller samples.
- Generates 1024x768@60 XGA raster timing on vclock (65 MHz), with pixel counters, hsync, vsync and data-enable.
- Paints the paddle rectangle over a background colour.
- Latches the box once per frame so on-screen geometry never tears mid-frame.

Parameters:
H_VISIBLE, 1024, active pixels per line
H_FP, 24, horizontal front porch (clocks)
H_SYNC, 136, hsync pulse width (clocks)
H_BP, 160, horizontal back porch (clocks)
V_VISIBLE, 768, active lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vsync pulse width (lines)
V_BP, 29, vertical back porch (lines)
PADDLE_RGB, 12'hFFF, colour inside the paddle box
BG_RGB, 12'h000, colour of active pixels outside the box

Ports:
vclock  in  1  pixel clock
reset  in  1  synchronous, active-high
minX  in  11  paddle left edge, inclusive
maxX  in  11  paddle right edge, inclusive
minY  in  10  paddle top edge, inclusive
maxY  in  10  paddle bottom edge, inclusive
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
de  out  1  data enable, high on active pixels
rgb  out  12  pixel colour {R4,G4,B4}; 0 when de=0
hcount  out  11  pixel column aligned with rgb/de/syncs
vcount  out  10  line number aligned with rgb/de/syncs
frame_start  out  1  one-cycle pulse aligned with pixel (0,0)

Behaviour:
- Reset: "reset, synchronous, active-high; clock vclock." When reset is high at a vclock edge:
  - Internal counters h=0, v=0; shadow box cleared to minX=1, maxX=0 (empty box).
  - Outputs: hsync=1, vsync=1, de=0, rgb=0, hcount=0, vcount=0, frame_start=0.
- Reset asserted mid-frame aborts the frame immediately.
  - The first edge after reset deasserts starts counting from (0,0).
  - Pixel (0,0) is presented one cycle later, with an empty box.
- Derived totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 1344; V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP = 806.
- Stage 0 counters:
  - h increments each clock and wraps H_TOTAL-1 -> 0.
  - v increments when h wraps, and wraps V_TOTAL-1 -> 0.
- Stage 1 registered outputs, 1 clock of latency from the counters:
  - hcount/vcount: the stage-0 h/v.
  - de = (h < H_VISIBLE) && (v < V_VISIBLE).
  - hsync = 0 iff H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC, i.e. h in 1048..1183.
  - vsync = 0 iff V_VISIBLE+V_FP <= v < V_VISIBLE+V_FP+V_SYNC, i.e. v in 771..776, for whole lines. vsync changes only on h=0 boundaries.
  - frame_start = (h==0 && v==0).
  - rgb = PADDLE_RGB if de && inside; BG_RGB if de && !inside; 0 otherwise.
- inside uses the shadow box with unsigned compares, edges inclusive: sminX <= h <= smaxX && sminY <= v <= smaxY.
- Degenerate boxes:
  - sminX > smaxX or sminY > smaxY means nothing is drawn.
  - Box coordinates beyond the visible area are clipped by de; no wrap.
- Shadow latch: on the clock where h==H_TOTAL-1 && v==V_TOTAL-1, copy minX/maxX/minY/maxY into shadow registers.
  - The new box takes effect from pixel (0,0) of the next frame.
  - Input changes at any other time, including the vsync-falling-edge update by the paddle controller, are invisible until the next latch point.
- Simultaneous reset and latch point: reset wins and the shadow box is cleared.
- No combinational path from inputs to outputs.

Test Plan:
- Reset held 3 cycles, then released -> during reset hsync=vsync=1, de=0, rgb=0. frame_start=1 exactly one cycle after the first non-reset edge, with hcount=0, vcount=0.
- Free-run 2 frames -> per line, de high for 1024 consecutive cycles; hsync low for exactly 136 cycles starting 1048 cycles after de rises. vsync falling edges are exactly 1083264 cycles apart and vsync stays low for 8064 cycles.
- Box minX=400, maxX=700, minY=400, maxY=700, applied before the latch point:
  - Next frame: rgb=FFF at (400,400), (700,700) and (550,550).
  - rgb=000 at (399,400), (701,700), (400,399) and (400,701).
  - rgb=0 whenever de=0.
- Change minX 400 -> 404 mid-frame at (0,300) -> rows 300..700 of the current frame still start at x=400; the next frame starts at x=404.
- Degenerate box minX=500, maxX=499 -> entire frame BG_RGB. Box minX=1000, maxX=1500 -> columns 1000..1023 FFF and no colour in blanking.
- Reset pulse at (600,500) mid-frame -> outputs return to reset values the next cycle. Raster restarts at (0,0) and the box is empty until the following latch.
